// File: rtl/muldiv_sequencer_if.sv
// Handshake/operand bundle between the multicycle control FSM and the multiply/divide sequencer.
// With MULDIV_UNSIGNED_EN defined the bundle also carries unsigned_op.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    // start_mult/start_div are one-cycle requests, honoured only while the sequencer is idle
    // (busy=0 and not in its done/div_zero cycle); a and b are sampled in that same cycle.
    // done/div_zero are one-cycle completion pulses that need no acknowledge.
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
    logic             unsigned_op;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hilo_write;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       state;

    modport master (
        output start_mult, start_div, a, b,
`ifdef MULDIV_UNSIGNED_EN
        output unsigned_op,
`endif
        input  busy, done, div_zero, hilo_write, hi, lo, state
    );

    modport slave (
        input  start_mult, start_div, a, b,
`ifdef MULDIV_UNSIGNED_EN
        input  unsigned_op,
`endif
        output busy, done, div_zero, hilo_write, hi, lo, state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide with HI/LO result registers.
// Optional MULDIV_UNSIGNED_EN adds unsigned_op for multu/divu.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4,
        S_DZ   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             uns_q, uns_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             uns_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last_step;

`ifdef MULDIV_UNSIGNED_EN
    assign uns_in = bus.unsigned_op;
`else
    assign uns_in = 1'b0;
`endif

    assign a_mag     = (!uns_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (!uns_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // Booth step on a WIDTH+1 bit upper half, so -2^(W-1) as multiplicand cannot overflow the add.
    logic [WIDTH:0]   upper_x, mcand_x, sum_x;
    logic [AW-1:0]    acc_step;

    always_comb begin
        upper_x = uns_q ? {1'b0, acc_q[AW-1:WIDTH+1]} : {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
        mcand_x = uns_q ? {1'b0, mcand_q} : {mcand_q[WIDTH-1], mcand_q};
        sum_x   = upper_x;
        if (uns_q) begin
            if (acc_q[1]) sum_x = upper_x + mcand_x;
        end else begin
            case (acc_q[1:0])
                2'b01:   sum_x = upper_x + mcand_x;
                2'b10:   sum_x = upper_x - mcand_x;
                default: sum_x = upper_x;
            endcase
        end
        acc_step = {sum_x, acc_q[WIDTH:1]};
    end

    // Restoring division step: quotient bits shift in from the bottom of quo_q as the dividend shifts out.
    logic [WIDTH:0]   rem_shift, trial;
    logic [WIDTH-1:0] rem_step, quo_step;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, mcand_q};
        rem_step  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            uns_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            uns_q   <= uns_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        uns_d   = uns_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_mult) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, bus.b, 1'b0};
                    mcand_d = bus.a;
                    uns_d   = uns_in;
                end else if (bus.start_div) begin
                    if (bus.b == '0) begin
                        state_d = S_DZ;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        mcand_d = b_mag;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        uns_d   = uns_in;
                        negq_d  = !uns_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        negr_d  = !uns_in && bus.a[WIDTH-1];
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    hi_d    = acc_step[AW-1:WIDTH+1];
                    lo_d    = acc_step[WIDTH:1];
                end
            end
            S_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) state_d = S_FIX;
            end
            S_FIX: begin
                // Result lands in hi/lo on this edge so it is visible during the DONE cycle.
                hi_d    = negr_q ? -rem_q : rem_q;
                lo_d    = negq_q ? -quo_q : quo_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_DZ: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.done       = (state_q == S_DONE);
    assign bus.hilo_write = (state_q == S_DONE);
    assign bus.div_zero   = (state_q == S_DZ);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against a 64-bit model,
// and hand sequences for div-by-zero, ignored starts and mid-operation reset.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk;
  logic reset;
  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) return sa * sb;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One operation: drive the start for one cycle, wait for done/div_zero, check latency and result.
  task automatic do_op(input bit is_div, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic [63:0] exp_v, input string name, input int poke_at,
                       input bit poke_done, input bit both);
    int lat;
    int n;
    bit dz;
    bit seen;
    logic [63:0] e;
    dz  = is_div && (b_v == 32'd0);
    lat = !is_div ? W + 1 : (dz ? 1 : W + 2);
    if (!dz) begin
      exp_q.push_back(exp_v);
      model_hilo = exp_v;
    end
    @(negedge clk);
    bus.start_mult = !is_div;
    bus.start_div  = is_div || both;
    bus.a = a_v;
    bus.b = b_v;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a = $urandom;
    bus.b = 32'd0;
    n = 1;
    while (n <= W + 10) begin
      if (bus.done || bus.div_zero) break;
      if (n == 1) check({name, "_busy"}, 64'(bus.busy), 64'd1);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      if (n == poke_at) begin
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
        bus.a = $urandom;
      end
      @(negedge clk);
      n++;
    end
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(lat));
    if (dz) begin
      check({name, "_dz_flags"}, {62'd0, bus.div_zero, bus.done}, {62'd0, 1'b1, 1'b0});
      check({name, "_hilo_held"}, {bus.hi, bus.lo}, model_hilo);
    end else begin
      check({name, "_done_we"}, {62'd0, bus.done, bus.hilo_write}, {62'd0, 1'b1, 1'b1});
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 64'd1, 64'd0 + 64'(exp_q.size()));
      end else begin
        e = exp_q.pop_front();
        check({name, "_hilo"}, {bus.hi, bus.lo}, e);
      end
    end
    if (poke_done) begin
      bus.start_mult = 1'b1;
      bus.a = 32'd9;
      bus.b = 32'd9;
    end
    @(negedge clk);
    bus.start_mult = 1'b0;
    check({name, "_idle_after"}, {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    check({name, "_state_idle"}, 64'(bus.state), 64'd0);
    if (poke_done) begin
      seen = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clk);
        if (bus.done || bus.div_zero || bus.busy) seen = 1'b1;
      end
      check({name, "_no_extra_op"}, 64'(seen), 64'd0);
      check({name, "_hilo_stable"}, {bus.hi, bus.lo}, model_hilo);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int n;
    n_cmp = 0;
    n_bad = 0;
    model_hilo = 64'd0;
    reset = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
`ifdef MULDIV_UNSIGNED_EN
    bus.unsigned_op = 1'b0;
`endif

    vecs[0]  = '{1'b0, 32'h0000_0003, 32'hFFFF_FFFC, 64'hFFFFFFFF_FFFFFFF4, "mul_3_m4"};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2"};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "div_ovf"};
    vecs[3]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFFFFFF_00000001, "mul_max_max"};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, "mul_min_min"};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 64'hFFFFFFFF_80000000, "mul_min_1"};
    vecs[6]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "div_7_m2"};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFFFFFF_00000003, "div_m7_m2"};
    vecs[8]  = '{1'b1, 32'd100,       32'd7,         64'h00000002_0000000E, "div_100_7"};
    vecs[9]  = '{1'b0, 32'd0,         32'd12345,     64'h00000000_00000000, "mul_zero"};
    vecs[10] = '{1'b1, 32'd3,         32'd5,         64'h00000003_00000000, "div_small"};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'd1,         64'h00000000_7FFFFFFF, "div_by_1"};

    repeat (3) @(negedge clk);
    check("reset_flags", {60'd0, bus.busy, bus.done, bus.div_zero, bus.hilo_write}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_state", 64'(bus.state), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op(1'b0, ra, rb, model(1'b0, ra, rb), "rand_mul", 0, 1'b0, 1'b0);
      rb = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i[0]) rb = -rb;
      do_op(1'b1, ra, rb, model(1'b1, ra, rb), "rand_div", 0, 1'b0, 1'b0);
    end

    // Load hi/lo = 0x11/0x22, then divide by zero: flag only, hi/lo untouched.
    do_op(1'b1, 32'h451, 32'h20, 64'h00000011_00000022, "div_setup", 0, 1'b0, 1'b0);
    do_op(1'b1, 32'd5, 32'd0, 64'd0, "div_zero", 0, 1'b1, 1'b0);

    // Starts pulsed mid-operation and during DONE are ignored.
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "div_ovf_poke", 5, 1'b1, 1'b0);
    // Both starts together: multiply wins and the divide request is dropped.
    do_op(1'b0, 32'd5, 32'd6, 64'd30, "both_starts", 0, 1'b1, 1'b1);

    // Reset in the middle of a multiply aborts it with everything cleared.
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.a = 32'h7FFF_FFFF;
    bus.b = 32'h7FFF_FFFF;
    @(negedge clk);
    bus.start_mult = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_flags", {60'd0, bus.busy, bus.done, bus.div_zero, bus.hilo_write}, 64'd0);
    check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop_reset_state", 64'(bus.state), 64'd0);
    reset = 1'b0;
    model_hilo = 64'd0;
    do_op(1'b0, 32'd2, 32'd3, 64'd6, "mul_after_reset", 0, 1'b1, 1'b0);

`ifdef MULDIV_UNSIGNED_EN
    bus.unsigned_op = 1'b1;
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 64'h00000001_FFFFFFFE, "multu", 0, 1'b0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, 64'h00000001_7FFFFFFF, "divu", 0, 1'b0, 1'b0);
    bus.unsigned_op = 1'b0;
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, "mult_signed", 0, 1'b0, 1'b0);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
